// File: rtl/alu_pkg.sv
// Shared ALU operation encodings, legality check and execute-unit FSM states.
// Imported by the control decoder and the serial execute unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR)  ||
           (op == ALU_ADD) || (op == ALU_SUB) ||
           (op == ALU_SLT) || (op == ALU_XOR);
  endfunction

  function automatic logic is_sub_op(input logic [3:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// One DIGIT-wide slice of the serial ALU: add/subtract with carry
// chaining, or a plain bitwise logic op.
module alu_digit_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [3:0]       op_i,
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] y_o,
  output logic             c_o
);

  logic [DIGIT-1:0] bx;
  logic [DIGIT:0]   sum;

  always_comb begin
    bx  = is_sub_op(op_i) ? ~b_i : b_i;
    sum = {1'b0, a_i} + {1'b0, bx} + {{DIGIT{1'b0}}, c_i};
    c_o = sum[DIGIT];
    y_o = sum[DIGIT-1:0];
    unique case (op_i)
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      default: y_o = sum[DIGIT-1:0];
    endcase
  end

endmodule

// File: rtl/alu_serial_exec.sv
// Digit-serial execute unit: LSB-first, DIGIT bits per cycle,
// valid/ready on both the operand and the result side.
module alu_serial_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;

  logic [DIGIT-1:0]       dig_y;
  logic                   dig_c;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;
  logic [WIDTH-1:0]       res_fin;
  logic                   ovf;
  logic                   last;

  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .op_i (op_q),
    .a_i  (a_q[DIGIT-1:0]),
    .b_i  (b_q[DIGIT-1:0]),
    .c_i  (carry_q),
    .y_o  (dig_y),
    .c_o  (dig_c)
  );

  // On the last digit the slice MSB is the sign of the full result.
  always_comb begin
    res_cat   = {dig_y, res_q};
    res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];
    last      = (cnt_q == CW'(NDIG - 1));
    ovf       = (a_q[DIGIT-1] != b_q[DIGIT-1]) &&
                (dig_y[DIGIT-1] != a_q[DIGIT-1]);
    res_fin   = res_shift;
    if (op_q == ALU_SLT)
      res_fin = {{(WIDTH-1){1'b0}}, dig_y[DIGIT-1] ^ ovf};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = operation;
          a_d     = a;
          b_d     = b;
          carry_d = is_sub_op(operation);
          cnt_d   = '0;
          if (is_legal_op(operation)) begin
            state_d = BUSY;
            ill_d   = 1'b0;
          end else begin
            state_d = DONE;
            res_d   = '0;
            zero_d  = 1'b1;
            ill_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_c;
        cnt_d   = cnt_q + 1'b1;
        res_d   = res_shift;
        if (last) begin
          state_d = DONE;
          res_d   = res_fin;
          zero_d  = (res_fin == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;

endmodule
